// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, runtime frame format,
// per-word error flags and a first-word-fall-through AXI-Stream FIFO with RTS flow control.
module uart_rx_ovs #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 27,
  parameter logic [8:0]  DEFAULT_CFG = 9'h040,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [24:0]                 s_axis_config_tdata,
  input  logic                        s_axis_config_tvalid,
  output logic                        s_axis_config_tready,
  output logic [8:0]                  m_axis_tdata,
  output logic [3:0]                  m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  input  logic                        rxd,
  output logic                        rtsn
);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2);
  localparam logic [TickW-1:0] TickS0   = TickW'(OVERSAMPLE / 2 - 2);
  localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickOne  = TickW'(1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]    CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW:0]    CntFull  = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0]    CntAfull = (PtrW + 1)'(AFULL_LEVEL);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkWait} state_e;

  state_e           state_q;
  logic [15:0]      div_q, div_cnt_q;
  logic [2:0]       par_q;
  logic [3:0]       nbits_q, bit_cnt_q;
  logic             two_stop_q, en_q, cfg_rdy_q;
  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [1:0]       smp_q;
  logic [8:0]       shreg_q;
  logic             par_acc_q, par_err_q, frm_err_q, zero_q, stop2_q;

  logic       tick, at_mid, at_end, fall, bit_val, last_stop, brk_now, push, par_bad;
  logic [3:0] cfg_nb;
  logic [8:0] word_data;
  logic [2:0] word_user;

  assign tick      = (div_cnt_q == div_q - 16'd1);
  assign at_mid    = tick && (tick_cnt_q == TickMid);
  assign at_end    = tick && (tick_cnt_q == TickLast);
  assign fall      = rxd_prev_q && !rxd_sync_q;
  assign bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_sync_q) | (smp_q[1] & rxd_sync_q);
  assign last_stop = !two_stop_q || stop2_q;
  // With two stop bits the break decision was already folded into zero_q at stop 1.
  assign brk_now   = stop2_q ? zero_q : (zero_q && !bit_val);
  assign push      = (state_q == StStop) && at_mid && last_stop;
  assign word_data = brk_now ? 9'd0 : (shreg_q >> (4'd9 - nbits_q));
  assign word_user = {brk_now, frm_err_q | !bit_val | brk_now, par_err_q};
  assign cfg_nb    = s_axis_config_tdata[22:19];

  always_comb begin
    par_bad = 1'b0;
    case (par_q)
      3'd1:    par_bad = par_acc_q ^ bit_val;
      3'd2:    par_bad = !(par_acc_q ^ bit_val);
      3'd3:    par_bad = !bit_val;
      3'd4:    par_bad = bit_val;
      default: par_bad = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      div_q      <= 16'(DEFAULT_DIV);
      par_q      <= DEFAULT_CFG[2:0];
      nbits_q    <= DEFAULT_CFG[6:3];
      two_stop_q <= DEFAULT_CFG[7];
      en_q       <= DEFAULT_CFG[8];
      cfg_rdy_q  <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      zero_q     <= 1'b1;
      stop2_q    <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      if (state_q != StIdle) begin
        div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;
        if (tick) begin
          tick_cnt_q <= tick_cnt_q + TickOne;
          if (tick_cnt_q == TickS0) smp_q[0] <= rxd_sync_q;
          if (tick_cnt_q == TickS1) smp_q[1] <= rxd_sync_q;
        end
      end
      unique case (state_q)
        StIdle: begin
          cfg_rdy_q <= 1'b1;
          if (s_axis_config_tvalid && cfg_rdy_q) begin
            div_q      <= (s_axis_config_tdata[15:0] == 16'd0) ? 16'd1 : s_axis_config_tdata[15:0];
            par_q      <= s_axis_config_tdata[18:16];
            nbits_q    <= (cfg_nb inside {[4'd5:4'd9]}) ? cfg_nb : 4'd8;
            two_stop_q <= s_axis_config_tdata[23];
            en_q       <= s_axis_config_tdata[24];
          end
          if (en_q && fall) begin
            state_q    <= StStart;
            cfg_rdy_q  <= 1'b0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            zero_q     <= 1'b1;
            stop2_q    <= 1'b0;
          end
        end
        StStart: begin
          if (at_mid && bit_val) begin
            state_q   <= StIdle;
            cfg_rdy_q <= 1'b1;
          end else if (at_end) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (at_mid) begin
            shreg_q   <= {bit_val, shreg_q[8:1]};
            par_acc_q <= par_acc_q ^ bit_val;
            zero_q    <= zero_q && !bit_val;
          end
          if (at_end) begin
            if (bit_cnt_q == nbits_q - 4'd1) begin
              bit_cnt_q <= '0;
              state_q   <= (par_q != 3'd0) ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (at_mid) begin
            par_err_q <= par_bad;
            zero_q    <= zero_q && !bit_val;
          end
          if (at_end) state_q <= StStop;
        end
        StStop: begin
          if (at_mid && last_stop) begin
            state_q    <= brk_now ? StBrkWait : StIdle;
            cfg_rdy_q  <= !brk_now;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
          end else if (at_mid) begin
            frm_err_q <= frm_err_q || !bit_val;
            zero_q    <= zero_q && !bit_val;
          end else if (at_end) begin
            stop2_q <= 1'b1;
          end
        end
        StBrkWait: begin
          // Leave only after a full bit time of continuous idle-high line.
          if (tick) begin
            if (!rxd_sync_q) begin
              tick_cnt_q <= '0;
            end else if (tick_cnt_q == TickLast) begin
              state_q   <= StIdle;
              cfg_rdy_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [12:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            ovr_q, rtsn_q, wr_en, pop, full;
  logic [12:0]     rd_word;

  assign full    = (count_q == CntFull);
  assign wr_en   = push && !full;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign rd_word = mem_q[rd_ptr_q];

  assign m_axis_tvalid        = (count_q != '0);
  assign m_axis_tdata         = m_axis_tvalid ? rd_word[8:0] : 9'd0;
  assign m_axis_tuser         = m_axis_tvalid ? rd_word[12:9] : 4'd0;
  assign fill_level           = count_q;
  assign rtsn                 = rtsn_q;
  assign s_axis_config_tready = cfg_rdy_q;

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ovr_q, word_user, word_data};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      rtsn_q   <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      if (push && full) ovr_q <= 1'b1;
      else if (wr_en)   ovr_q <= 1'b0;
      rtsn_q <= (count_q >= CntAfull);
    end
  end

endmodule
